alu_iter: RTL and testbench
===========================

// Module: alu_iter
// PURPOSE
//  Parametrised MIPS-style integer ALU with valid/ready handshake on both sides and one output register.
//  Single-cycle ops: add/sub, logic, set-less-than, shifts, lui. Iterative multi-cycle ops: mult/multu/div/divu.
//  Sits between decode/regfile read and writeback. HI/LO results leave on result_hi/result.
// PARAMETERS
//  WIDTH      32  datapath width; even, >=8. SHW = $clog2(WIDTH) (localparam).
//  MULDIV_EN  1   0: mul/div ops complete in 1 cycle with result=result_hi=0 and illegal=1.
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      op/busA/busB valid
//  in_ready   out  1      ALU accepts the operation this cycle
//  op         in   4      operation code (alu_defs.vh)
//  busA       in   WIDTH  operand A (rs)
//  busB       in   WIDTH  operand B (rt/imm)
//  out_valid  out  1      result register holds an unconsumed result
//  out_ready  in   1      consumer accepts the result
//  result     out  WIDTH  main result / LO (product low, quotient)
//  result_hi  out  WIDTH  HI (product high, remainder); 0 for single-cycle ops
//  zero       out  1      result == 0
//  overflow   out  1      signed overflow (ADD/SUB only)
//  illegal    out  1      mul/div op while MULDIV_EN=0
//  busy       out  1      iterative op in progress
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, result, result_hi, zero, overflow, illegal, busy = 0. In-flight op discarded.
//  Accept: transfer when in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
//  Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, A SRA,
//            B LUI, C MULT, D MULTU, E DIV, F DIVU.
//  Single-cycle ops (0-B): result registered on the accept edge; out_valid=1 on the next cycle (latency 1).
//    ADD/SUB: wrap modulo 2^WIDTH; overflow = signed overflow. All other ops: overflow=0.
//    SLT/SLTU: result = {WIDTH-1 zeros, lt}.
//    Shifts: busA shifted by busB[SHW-1:0]; SRA sign-fills.
//    LUI: busB << WIDTH/2.
//  Iterative ops (C-F), MULDIV_EN=1: FSM IDLE -> RUN (WIDTH cycles, 1 bit/cycle) -> FIX (sign correction) -> IDLE.
//    Result registered at end of FIX; out_valid one cycle later. Latency accept->out_valid = WIDTH+2 cycles.
//    busy=1 in RUN and FIX.
//    Signed ops: operate on magnitudes, negate in FIX.
//      Product sign = signA ^ signB. Quotient sign = signA ^ signB. Remainder sign = dividend sign.
//    MULT/MULTU: {result_hi, result} = full 2*WIDTH product.
//    DIV/DIVU: result = quotient, result_hi = remainder.
//    Divide by zero: quotient = all ones, remainder = dividend; illegal=0.
//    DIV of MIN_INT by -1: quotient = MIN_INT, remainder = 0.
//  Output hold: result/flags/out_valid stable while out_valid & !out_ready.
//    Accept and consume in the same cycle are allowed (back-to-back, 1 op/cycle for single-cycle ops).
//  Operands/op are captured at accept; later input changes have no effect on the op in flight.
//  zero is computed from result only (not result_hi).
//  rst asserted mid-RUN: FSM to IDLE next edge; no out_valid is produced for the aborted op.
// STRUCTURE
//  alu_defs.vh: op code localparams; ALU_OP_W=4; IDLE/RUN/FIX state encodings.
//  Sub-module alu_muldiv_seq: shift-add multiplier + restoring divider sharing one 2*WIDTH accumulator.
//    Ports: start, signed, is_div, a, b -> done, lo, hi.
//    Top holds the handshake, the single-cycle datapath and the output register.
// TESTING
//  1. ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, out_valid 1 cycle after accept.
//     SUB 5-5 -> result 0, zero=1.
//  2. Back-to-back: out_ready=1, 4 single-cycle ops on consecutive cycles -> 4 results on consecutive cycles.
//     out_ready=0 -> in_ready=0 and result held unchanged.
//  3. MULT 0xFFFFFFFE*3 (-2*3) -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; out_valid exactly 34 cycles after accept.
//     busy=1 and in_ready=0 throughout.
//  4. DIV -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//     DIVU 9/0 -> q=0xFFFFFFFF, r=9.
//     DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
//  5. SRA 0x80000000 by busB=0x24 (uses 4) -> 0xF8000000.
//     SLTU 1,0xFFFFFFFF -> 1; SLT same -> 0.
//     LUI busB=0x1234 -> 0x12340000.
//  6. rst asserted at RUN cycle 10 of a DIVU -> out_valid never rises for it.
//     Next ADD accepted right after reset completes normally.

Source files
------------

// File: rtl/alu_iter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_iter_pkg : op codes and mul/div sequencer states for alu_iter  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_iter_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_NOR  = 4'h5,
      OP_SLT  = 4'h6,
      OP_SLTU = 4'h7,
      OP_SLL  = 4'h8,
      OP_SRL  = 4'h9,
      OP_SRA  = 4'hA,
      OP_LUI  = 4'hB,
      OP_MULT = 4'hC,
      OP_MULTU= 4'hD,
      OP_DIV  = 4'hE,
      OP_DIVU = 4'hF
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

   // Codes C..F are the iterative multiply/divide group.
   function automatic logic is_muldiv(input alu_op_t op);
      return (op[3:2] == 2'b11);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_muldiv_seq : 1 bit/cycle shift-add multiplier and restoring    |
// | divider sharing one 2*WIDTH accumulator. rev 1.0                   |
// +--------------------------------------------------------------------+
module alu_muldiv_seq
   import alu_iter_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH-1);

   md_state_t            state, state_nx;
   logic [SHW-1:0]       cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_step;
   logic [WIDTH-1:0]     mb;
   logic [WIDTH-1:0]     a_orig;
   logic                 div_r, neg_q, neg_r, b_zero;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_trial;
   logic [WIDTH-1:0]     div_diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo, rem;

   assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && start) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            mb     <= b_mag;
            a_orig <= a;
            div_r  <= is_div;
            neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= is_signed & a[WIDTH-1];
            b_zero <= (b == '0);
            cnt    <= '0;
         end else if (state == ST_RUN) begin
            acc <= acc_step;
            cnt <= cnt + SHW'(1);
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start) state_nx = ST_RUN;
         ST_RUN:  if (cnt == LAST) state_nx = ST_FIX;
         ST_FIX:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // One iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : {(WIDTH+1){1'b0}});
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_trial[WIDTH-1:0] - mb;
      if (div_r) begin
         if (div_trial >= {1'b0, mb})
            acc_step = {div_diff, acc[WIDTH-2:0], 1'b1};
         else
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // Sign correction, valid while in FIX.
   always_comb begin
      prod = neg_q ? -acc : acc;
      quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (!div_r) begin
         lo = prod[WIDTH-1:0];
         hi = prod[2*WIDTH-1:WIDTH];
      end else if (b_zero) begin
         lo = '1;
         hi = a_orig;
      end else begin
         lo = quo;
         hi = rem;
      end
   end

   assign done = (state == ST_FIX);
   assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_iter : MIPS-style ALU, valid/ready on both sides, registered   |
// | output, iterative mul/div. rev 1.0                                 |
// +--------------------------------------------------------------------+
module alu_iter
   import alu_iter_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit MULDIV_EN = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             illegal,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   alu_op_t          op_e;
   logic             accept, is_md, md_go;
   logic             md_done, md_busy;
   logic [WIDTH-1:0] md_lo, md_hi;
   logic [WIDTH-1:0] sc_res, sum, diff;
   logic             sc_ovf;
   logic [SHW-1:0]   shamt;

   assign op_e     = alu_op_t'(op);
   assign is_md    = is_muldiv(op_e);
   assign in_ready = !md_busy && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign md_go    = accept && is_md && MULDIV_EN;
   assign busy     = md_busy;
   assign shamt    = busB[SHW-1:0];

   if (MULDIV_EN) begin : g_muldiv
      alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
         .clk       (clk),
         .rst       (rst),
         .start     (md_go),
         .is_signed (!op[0]),
         .is_div    (op[1]),
         .a         (busA),
         .b         (busB),
         .done      (md_done),
         .busy      (md_busy),
         .lo        (md_lo),
         .hi        (md_hi)
      );
   end else begin : g_no_muldiv
      assign md_done = 1'b0;
      assign md_busy = 1'b0;
      assign md_lo   = '0;
      assign md_hi   = '0;
   end

   // Single-cycle datapath; mul/div codes fall to the zero default.
   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      sum    = busA + busB;
      diff   = busA - busB;
      case (op_e)
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (busA[WIDTH-1] == busB[WIDTH-1]) && (sum[WIDTH-1] != busA[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (busA[WIDTH-1] != busB[WIDTH-1]) && (diff[WIDTH-1] != busA[WIDTH-1]);
         end
         OP_AND:  sc_res = busA & busB;
         OP_OR:   sc_res = busA | busB;
         OP_XOR:  sc_res = busA ^ busB;
         OP_NOR:  sc_res = ~(busA | busB);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(busA) < $signed(busB))};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (busA < busB)};
         OP_SLL:  sc_res = busA << shamt;
         OP_SRL:  sc_res = busA >> shamt;
         OP_SRA:  sc_res = $signed(busA) >>> shamt;
         OP_LUI:  sc_res = busB << (WIDTH/2);
         default: ;
      endcase
   end

   // Output register: while stalled nothing can be accepted and no mul/div is running.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else if (accept && !md_go) begin
         out_valid <= 1'b1;
         result    <= sc_res;
         result_hi <= '0;
         zero      <= (sc_res == '0);
         overflow  <= sc_ovf;
         illegal   <= is_md && !MULDIV_EN;
      end else if (md_done) begin
         out_valid <= 1'b1;
         result    <= md_lo;
         result_hi <= md_hi;
         zero      <= (md_lo == '0);
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_iter : directed and random checks of alu_iter (WIDTH=32)    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_alu_iter;

   localparam longint MAXI = 64'sh7FFFFFFF;
   localparam longint MINI = -64'sh80000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = '0;
   logic [31:0] bus_a = '0;
   logic [31:0] bus_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result, result_hi;
   logic        zero, overflow, illegal, busy;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   alu_iter #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .busA      (bus_a),
      .busB      (bus_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal),
      .busy      (busy)
   );

   // Reference ALU from the arithmetic definitions, using 64-bit integers.
   function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [31:0] h, output logic ov);
      longint sa, sb, s;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0; h = '0; ov = 1'b0;
      case (o)
         4'h0: begin s = sa + sb; r = a + b; ov = (s > MAXI) || (s < MINI); end
         4'h1: begin s = sa - sb; r = a - b; ov = (s > MAXI) || (s < MINI); end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = ~(a | b);
         4'h6: r = (sa < sb) ? 32'd1 : 32'd0;
         4'h7: r = (a < b) ? 32'd1 : 32'd0;
         4'h8: r = a << b[4:0];
         4'h9: r = a >> b[4:0];
         4'hA: r = $signed(a) >>> b[4:0];
         4'hB: r = {b[15:0], 16'h0000};
         4'hC: begin p = sa * sb; r = p[31:0]; h = p[63:32]; end
         4'hD: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; h = p[63:32]; end
         4'hE: begin
            if (b == 32'h0) begin r = '1; h = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; h = '0; end
            else begin r = 32'(sa / sb); h = 32'(sa % sb); end
         end
         default: begin
            if (b == 32'h0) begin r = '1; h = a; end
            else begin r = a / b; h = a % b; end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h0000_0000;
         1: v = 32'h0000_0001;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000;
         4: v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issue one op (called at a negedge), wait for its result with out_ready=1.
   // lat = cycles from accept cycle to out_valid; -1 if never accepted.
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [31:0] h, output logic z,
                         output logic ov, output logic il, output int lat, output int bad_busy);
      int guard;
      bad_busy = 0; lat = -1; r = '0; h = '0; z = 1'b0; ov = 1'b0; il = 1'b0;
      op = o; bus_a = a; bus_b = b; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk); #1; guard++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      op = 4'($urandom); bus_a = $urandom; bus_b = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         if (!busy || in_ready) bad_busy++;
         @(negedge clk);
         lat++;
      end
      r = result; h = result_hi; z = zero; ov = overflow; il = illegal;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if ({out_valid, zero, overflow, illegal, busy} !== 5'b0) begin
         errs++;
         $display("FAIL reset_flags: got ov/z/o/i/b=%b want 00000", {out_valid, zero, overflow, illegal, busy});
      end
      vec++;
      if ({result, result_hi} !== 64'h0) begin
         errs++;
         $display("FAIL reset_results: got %h_%h want 0", result_hi, result);
      end
      rst = 1'b0;
      #1;
      vec++;
      if (in_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add_sub();
      logic [31:0] r, h; logic z, ov, il; int lat, bb;
      @(negedge clk);
      run_op(4'h0, 32'h7FFF_FFFF, 32'h1, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'h8000_0000 || ov !== 1'b1 || z !== 1'b0 || h !== 32'h0) begin
         errs++;
         $display("FAIL add_ovf: got r=%h ov=%b z=%b hi=%h want 80000000 1 0 0", r, ov, z, h);
      end
      vec++;
      if (lat !== 1) begin
         errs++;
         $display("FAIL add_latency: got %0d want 1", lat);
      end
      run_op(4'h1, 32'd5, 32'd5, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'h0 || z !== 1'b1 || ov !== 1'b0) begin
         errs++;
         $display("FAIL sub_zero: got r=%h z=%b ov=%b want 0 1 0", r, z, ov);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] er[4];
      logic [31:0] eh;
      logic        eo;
      logic [3:0]  o;
      logic [31:0] a, b;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         o = 4'($urandom_range(0, 11)); a = pick(); b = pick();
         model(o, a, b, er[k], eh, eo);
         op = o; bus_a = a; bus_b = b; in_valid = 1'b1;
         #1;
         vec++;
         if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, in_ready);
         end
         if (k > 0) begin
            vec++;
            if (out_valid !== 1'b1 || result !== er[k-1]) begin
               errs++;
               $display("FAIL b2b_result[%0d]: got v=%b r=%h want 1 %h", k-1, out_valid, result, er[k-1]);
            end
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      op = 4'h0; bus_a = 32'd10; bus_b = 32'd20; in_valid = 1'b1;
      #1;
      vec++;
      if (out_valid !== 1'b1 || result !== er[3]) begin
         errs++;
         $display("FAIL b2b_result[3]: got v=%b r=%h want 1 %h", out_valid, result, er[3]);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         vec++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== er[3]) begin
            errs++;
            $display("FAIL hold[%0d]: got rdy=%b v=%b r=%h want 0 1 %h", k, in_ready, out_valid, result, er[3]);
         end
      end
      out_ready = 1'b1;
      #1;
      vec++;
      if (in_ready !== 1'b1) begin
         errs++;
         $display("FAIL hold_release_ready: got %b want 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      vec++;
      if (out_valid !== 1'b1 || result !== 32'd30) begin
         errs++;
         $display("FAIL hold_release_result: got v=%b r=%h want 1 0000001e", out_valid, result);
      end
   endtask

   task automatic test_mult();
      logic [31:0] r, h; logic z, ov, il; int lat, bb;
      run_op(4'hC, 32'hFFFF_FFFE, 32'd3, r, h, z, ov, il, lat, bb);
      vec++;
      if (h !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFFA) begin
         errs++;
         $display("FAIL mult_neg: got %h_%h want ffffffff_fffffffa", h, r);
      end
      vec++;
      if (lat !== 34 || bb !== 0) begin
         errs++;
         $display("FAIL mult_timing: got lat=%0d busy_gaps=%0d want 34 0", lat, bb);
      end
   endtask

   task automatic test_div();
      logic [31:0] r, h; logic z, ov, il; int lat, bb;
      run_op(4'hE, 32'hFFFF_FFF9, 32'd2, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
         errs++;
         $display("FAIL div_neg: got q=%h r=%h want fffffffd ffffffff", r, h);
      end
      run_op(4'hF, 32'd9, 32'd0, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'hFFFF_FFFF || h !== 32'd9 || il !== 1'b0) begin
         errs++;
         $display("FAIL divu_by_zero: got q=%h r=%h il=%b want ffffffff 00000009 0", r, h, il);
      end
      run_op(4'hE, 32'h8000_0000, 32'hFFFF_FFFF, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'h8000_0000 || h !== 32'h0) begin
         errs++;
         $display("FAIL div_min_by_m1: got q=%h r=%h want 80000000 0", r, h);
      end
   endtask

   task automatic test_misc();
      logic [31:0] r, h; logic z, ov, il; int lat, bb;
      run_op(4'hA, 32'h8000_0000, 32'h24, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'hF800_0000) begin
         errs++;
         $display("FAIL sra: got %h want f8000000", r);
      end
      run_op(4'h7, 32'd1, 32'hFFFF_FFFF, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'd1) begin
         errs++;
         $display("FAIL sltu: got %h want 00000001", r);
      end
      run_op(4'h6, 32'd1, 32'hFFFF_FFFF, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'd0 || z !== 1'b1) begin
         errs++;
         $display("FAIL slt: got r=%h z=%b want 0 1", r, z);
      end
      run_op(4'hB, 32'hDEAD_BEEF, 32'h1234, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'h1234_0000) begin
         errs++;
         $display("FAIL lui: got %h want 12340000", r);
      end
   endtask

   task automatic test_random();
      logic [31:0] r, h, er, eh; logic z, ov, il, eo; int lat, bb, elat;
      logic [3:0] o; logic [31:0] a, b;
      for (int n = 0; n < 120; n++) begin
         o = 4'($urandom_range(0, 15)); a = pick(); b = pick();
         model(o, a, b, er, eh, eo);
         elat = (o >= 4'hC) ? 34 : 1;
         run_op(o, a, b, r, h, z, ov, il, lat, bb);
         vec++;
         if (r !== er || h !== eh || z !== (er == 32'h0) || ov !== eo || il !== 1'b0) begin
            errs++;
            $display("FAIL rand[%0d] op=%h a=%h b=%h: got %h_%h z%b o%b i%b want %h_%h z%b o%b i0",
                     n, o, a, b, h, r, z, ov, il, eh, er, (er == 32'h0), eo);
         end
         vec++;
         if (lat !== elat || bb !== 0) begin
            errs++;
            $display("FAIL rand_timing[%0d] op=%h: got lat=%0d gaps=%0d want %0d 0", n, o, lat, bb, elat);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] r, h; logic z, ov, il; int lat, bb, seen;
      op = 4'hF; bus_a = 32'd1000; bus_b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      vec++;
      if (busy !== 1'b1) begin
         errs++;
         $display("FAIL abort_busy_before: got %b want 1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid || busy) seen++;
         @(negedge clk);
      end
      vec++;
      if (seen !== 0) begin
         errs++;
         $display("FAIL abort_no_output: got %0d active cycles want 0", seen);
      end
      run_op(4'h0, 32'd100, 32'd23, r, h, z, ov, il, lat, bb);
      vec++;
      if (r !== 32'd123 || lat !== 1) begin
         errs++;
         $display("FAIL abort_next_add: got r=%h lat=%0d want 0000007b 1", r, lat);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_back_to_back();
      test_mult();
      test_div();
      test_misc();
      test_random();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
`default_nettype wire
